// File: rtl/pb_gesture_decoder_pkg.sv
// Shared types and helpers for the push-button gesture decoder.
package pb_gesture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRST_DOWN,
    WAIT_SECOND,
    SECOND_DOWN,
    LONG_HELD
  } gesture_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pb_gesture_decoder_timer.sv
// Shared up-counting cycle timer; clear wins over enable and the count never wraps
// in use because the controller clears it on every terminal compare.
module gesture_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pb_gesture_decoder.sv
// Classifies debounced press/release pulses into click, double-click, long-press
// and auto-repeat pulses.
//
//   state       | meaning
//   IDLE        | no button activity in progress
//   FIRST_DOWN  | first press held, timing towards long press
//   WAIT_SECOND | first press released, timing the double-click gap
//   SECOND_DOWN | second press held, double click on release
//   LONG_HELD   | long press held, emitting periodic repeat ticks
module pb_gesture_decoder
  import pb_gesture_pkg::*;
#(
  parameter int LONG_CYCLES   = 1000,
  parameter int GAP_CYCLES    = 250,
  parameter int REPEAT_CYCLES = 100,
  parameter int CNT_WIDTH     = $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES))
) (
  input  logic clk,
  input  logic rst,
  input  logic pressed_pulse,
  input  logic released_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST    = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

  gesture_state_t       state;
  gesture_state_t       state_nxt;
  logic [CNT_WIDTH-1:0] count;
  logic                 timer_clear;
  logic                 timer_en;
  logic                 press_ev;
  logic                 release_ev;
  logic                 fire_single;
  logic                 fire_double;
  logic                 fire_long;
  logic                 fire_repeat;

  // A simultaneous press and release is treated as a release alone.
  assign press_ev   = pressed_pulse & ~released_pulse;
  assign release_ev = released_pulse;

  gesture_timer #(
    .WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .enable(timer_en),
    .count (count)
  );

  always_comb begin
    state_nxt   = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    fire_single = 1'b0;
    fire_double = 1'b0;
    fire_long   = 1'b0;
    fire_repeat = 1'b0;
    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (press_ev) state_nxt = FIRST_DOWN;
      end
      FIRST_DOWN: begin
        timer_en = 1'b1;
        if (release_ev) begin
          state_nxt   = WAIT_SECOND;
          timer_clear = 1'b1;
        end else if (count == LONG_LAST) begin
          state_nxt   = LONG_HELD;
          fire_long   = 1'b1;
          timer_clear = 1'b1;
        end
      end
      WAIT_SECOND: begin
        timer_en = 1'b1;
        if (press_ev) begin
          state_nxt   = SECOND_DOWN;
          timer_clear = 1'b1;
        end else if (count == GAP_LAST) begin
          state_nxt   = IDLE;
          fire_single = 1'b1;
          timer_clear = 1'b1;
        end
      end
      SECOND_DOWN: begin
        timer_clear = 1'b1;
        if (release_ev) begin
          state_nxt   = IDLE;
          fire_double = 1'b1;
        end
      end
      LONG_HELD: begin
        timer_en = 1'b1;
        if (release_ev) begin
          state_nxt   = IDLE;
          timer_clear = 1'b1;
        end else if (count == REPEAT_LAST) begin
          fire_repeat = 1'b1;
          timer_clear = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        timer_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != IDLE);
      single_click <= fire_single;
      double_click <= fire_double;
      long_press   <= fire_long;
      repeat_tick  <= fire_repeat;
    end
  end

endmodule

// File: tb/tb_pb_gesture_decoder.sv
// Bench for pb_gesture_decoder: directed gesture scenarios plus randomized pulse
// traffic, all checked every cycle against an elapsed-time reference model.
module tb_pb_gesture_decoder;

  localparam int L = 8;
  localparam int G = 4;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pressed_pulse = 1'b0;
  logic released_pulse = 1'b0;
  logic single_click, double_click, long_press, repeat_tick, busy;

  pb_gesture_decoder #(
    .LONG_CYCLES  (L),
    .GAP_CYCLES   (G),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pressed_pulse (pressed_pulse),
    .released_pulse(released_pulse),
    .single_click  (single_click),
    .double_click  (double_click),
    .long_press    (long_press),
    .repeat_tick   (repeat_tick),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  bit chk_en = 1'b0;

  // Model: what the button is doing, and the edge at which that activity began.
  localparam int M_IDLE = 0, M_HOLD1 = 1, M_GAP = 2, M_HOLD2 = 3, M_LONG = 4;
  int m_activity = M_IDLE;
  int m_since = 0;
  logic [4:0] m_out = '0;  // {single, double, long, repeat, busy}

  // Per-output logs (0 single, 1 double, 2 long, 3 repeat, 4 busy), cycles relative to base.
  int cnt_d[5], first_d[5], last_d[5];
  int cnt_m[5], first_m[5], last_m[5];

  task automatic model_step(input logic r_s, input logic p, input logic rl);
    logic [3:0] g;
    int el;
    g  = 4'b0000;
    el = cyc - m_since;
    if (r_s) begin
      m_activity = M_IDLE;
    end else begin
      case (m_activity)
        M_IDLE: if (p && !rl) begin m_activity = M_HOLD1; m_since = cyc; end
        M_HOLD1:
          if (rl) begin m_activity = M_GAP; m_since = cyc; end
          else if (el == L) begin g[1] = 1'b1; m_activity = M_LONG; m_since = cyc; end
        M_GAP:
          if (p && !rl) m_activity = M_HOLD2;
          else if (el == G) begin g[3] = 1'b1; m_activity = M_IDLE; end
        M_HOLD2: if (rl) begin g[2] = 1'b1; m_activity = M_IDLE; end
        default:
          if (rl) m_activity = M_IDLE;
          else if (el == R) begin g[0] = 1'b1; m_since = cyc; end
      endcase
    end
    m_out = {g, m_activity != M_IDLE};
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = 0; first_d[i] = -1; last_d[i] = -1;
      cnt_m[i] = 0; first_m[i] = -1; last_m[i] = -1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, expv);
    end
  endtask

  // Pins both the DUT log and the model log to hand-computed cycles.
  task automatic pin(input string nm, input int idx, input int ecnt, input int efirst, input int elast);
    chk({nm, " dut count"}, cnt_d[idx], ecnt);
    chk({nm, " dut first"}, first_d[idx], efirst);
    chk({nm, " dut last"}, last_d[idx], elast);
    chk({nm, " model count"}, cnt_m[idx], ecnt);
    chk({nm, " model first"}, first_m[idx], efirst);
    chk({nm, " model last"}, last_m[idx], elast);
  endtask

  always @(posedge clk) begin
    logic [4:0] d;
    int v;
    cyc = cyc + 1;
    model_step(rst, pressed_pulse, released_pulse);
    #1;
    d = {single_click, double_click, long_press, repeat_tick, busy};
    if (chk_en) begin
      checks++;
      if (d !== m_out) begin
        errors++;
        $display("FAIL cycle %0d outputs actual %b expected %b", cyc, d, m_out);
      end
    end
    v = cyc + 1 - base;
    for (int i = 0; i < 5; i++) begin
      if (d[4-i] === 1'b1) begin
        cnt_d[i]++;
        if (first_d[i] < 0) first_d[i] = v;
        last_d[i] = v;
      end
      if (m_out[4-i]) begin
        cnt_m[i]++;
        if (first_m[i] < 0) first_m[i] = v;
        last_m[i] = v;
      end
    end
  end

  // Pulse times are relative cycles; -1 means never.
  task automatic run_scn(input int p0, input int r0, input int p1, input int r1, input int rs);
    @(negedge clk) rst = 1'b1;
    pressed_pulse = 1'b0;
    released_pulse = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    clear_logs();
    base = cyc;
    for (int k = 1; k <= 40; k++) begin
      pressed_pulse  = (k == p0) || (k == p1);
      released_pulse = (k == r0) || (k == r1);
      rst            = (k == rs);
      @(negedge clk);
    end
    pressed_pulse  = 1'b0;
    released_pulse = 1'b0;
    rst            = 1'b0;
  endtask

  initial begin
    int dens;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;

    run_scn(10, 13, -1, -1, -1);
    pin("single click: single", 0, 1, 18, 18);
    pin("single click: double", 1, 0, -1, -1);
    pin("single click: long", 2, 0, -1, -1);
    pin("single click: busy", 4, 7, 11, 17);

    run_scn(10, 12, 15, 17, -1);
    pin("double click: double", 1, 1, 18, 18);
    pin("double click: single", 0, 0, -1, -1);
    pin("double click: busy", 4, 7, 11, 17);

    run_scn(10, 30, -1, -1, -1);
    pin("long press: long", 2, 1, 19, 19);
    pin("long press: repeat", 3, 3, 22, 28);
    pin("long press: single", 0, 0, -1, -1);
    pin("long press: busy", 4, 20, 11, 30);

    run_scn(10, 18, -1, -1, -1);
    pin("long boundary: long", 2, 0, -1, -1);
    pin("long boundary: single", 0, 1, 23, 23);
    pin("long boundary: busy", 4, 12, 11, 22);

    run_scn(10, 12, 16, 18, -1);
    pin("gap boundary: double", 1, 1, 19, 19);
    pin("gap boundary: single", 0, 0, -1, -1);
    pin("gap boundary: busy", 4, 8, 11, 18);

    run_scn(10, 16, -1, -1, 14);
    pin("reset mid-op: single", 0, 0, -1, -1);
    pin("reset mid-op: double", 1, 0, -1, -1);
    pin("reset mid-op: long", 2, 0, -1, -1);
    pin("reset mid-op: repeat", 3, 0, -1, -1);
    pin("reset mid-op: busy", 4, 4, 11, 14);

    // Randomized traffic: pulse density varies per block to reach every timeout.
    dens = 4;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) dens = 3 + $urandom_range(0, 22);
      pressed_pulse  = ($urandom_range(0, dens - 1) == 0);
      released_pulse = ($urandom_range(0, dens - 1) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    pressed_pulse  = 1'b0;
    released_pulse = 1'b0;
    rst            = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
